// File: rtl/nvdla_dbb_initiator.sv
// Burst initiator: turns HWPE-side commands into single NVDLA DBB read or write bursts.
// Request fields are registered; beat data passes straight through with no buffering.
module nvdla_dbb_initiator #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 64,
    parameter int unsigned IDW  = 8,
    parameter int unsigned LENW = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    // command
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [AW-1:0]     cmd_addr_i,
    input  logic [LENW-1:0]   cmd_len_i,
    // write-data stream sink
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [DW-1:0]     wdata_data_i,
    input  logic [DW/8-1:0]   wdata_strb_i,
    // read-data stream source
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [DW-1:0]     rdata_data_o,
    output logic [DW/8-1:0]   rdata_strb_o,
    // DBB write request
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [AW-1:0]     aw_addr_o,
    output logic [LENW-1:0]   aw_len_o,
    output logic [IDW-1:0]    aw_id_o,
    // DBB write data
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [DW-1:0]     w_data_o,
    output logic [DW/8-1:0]   w_strb_o,
    output logic              w_last_o,
    // DBB write response
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [IDW-1:0]    b_id_i,
    // DBB read request
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [AW-1:0]     ar_addr_o,
    output logic [LENW-1:0]   ar_len_o,
    output logic [IDW-1:0]    ar_id_o,
    // DBB read data
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [DW-1:0]     r_data_i,
    input  logic [IDW-1:0]    r_id_i,
    input  logic              r_last_i,
    // status
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

    state_e            state_q;
    logic [AW-1:0]     addr_q;
    logic [LENW-1:0]   len_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    id_cnt_q;
    logic [LENW-1:0]   beat_q;
    logic              err_q;

    logic last_beat;
    logic r_hs;
    logic w_hs;

    assign last_beat = (beat_q == len_q);
    assign r_hs      = (state_q == StR) && r_valid_i && rdata_ready_i;
    assign w_hs      = (state_q == StW) && wdata_valid_i && w_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            id_cnt_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            id_cnt_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        addr_q   <= cmd_addr_i;
                        len_q    <= cmd_len_i;
                        id_q     <= id_cnt_q;
                        id_cnt_q <= id_cnt_q + 1'b1;
                        beat_q   <= '0;
                        state_q  <= cmd_write_i ? StAw : StAr;
                    end
                end
                StAr: if (ar_ready_i) state_q <= StR;
                StR: begin
                    if (r_hs) begin
                        // Protocol errors are flagged but never change the beat sequencing.
                        if (r_id_i != id_q || r_last_i != last_beat) err_q <= 1'b1;
                        if (last_beat) begin
                            beat_q  <= '0;
                            state_q <= StIdle;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StAw: if (aw_ready_i) state_q <= StW;
                StW: begin
                    if (w_hs) begin
                        if (last_beat) begin
                            beat_q  <= '0;
                            state_q <= StB;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StB: begin
                    if (b_valid_i) begin
                        if (b_id_i != id_q) err_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign aw_addr_o    = addr_q;
    assign aw_len_o     = len_q;
    assign aw_id_o      = id_q;
    assign ar_addr_o    = addr_q;
    assign ar_len_o     = len_q;
    assign ar_id_o      = id_q;
    assign w_data_o     = wdata_data_i;
    assign w_strb_o     = wdata_strb_i;
    assign rdata_data_o = r_data_i;
    assign rdata_strb_o = '1;
    assign err_o        = err_q;

    always_comb begin
        cmd_ready_o   = (state_q == StIdle);
        busy_o        = (state_q != StIdle);
        ar_valid_o    = (state_q == StAr);
        aw_valid_o    = (state_q == StAw);
        b_ready_o     = (state_q == StB);
        rdata_valid_o = (state_q == StR) && r_valid_i;
        r_ready_o     = (state_q == StR) && rdata_ready_i;
        w_valid_o     = (state_q == StW) && wdata_valid_i;
        wdata_ready_o = (state_q == StW) && w_ready_i;
        w_last_o      = (state_q == StW) && last_beat;
        done_o        = (r_hs && last_beat) || ((state_q == StB) && b_valid_i);
    end

endmodule

// File: tb/tb_nvdla_dbb_initiator.sv
// Self-checking bench for nvdla_dbb_initiator: bench-side DBB target and HWPE streams,
// scoreboard queue of expected beats popped as the DUT presents them.
module tb_nvdla_dbb_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [63:0] wdata_data;
    logic [7:0]  wdata_strb;
    logic        rdata_valid, rdata_ready;
    logic [63:0] rdata_data;
    logic [7:0]  rdata_strb;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_len;
    logic [7:0]  aw_id;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [7:0]  b_id;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_len;
    logic [7:0]  ar_id;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic [7:0]  r_id;
    logic        busy, done, err;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_id = 8'd0;
    logic [71:0] sb[$];

    always #5 clk = ~clk;

    nvdla_dbb_initiator dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
        .wdata_data_i(wdata_data), .wdata_strb_i(wdata_strb),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
        .rdata_data_o(rdata_data), .rdata_strb_o(rdata_strb),
        .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
        .aw_len_o(aw_len), .aw_id_o(aw_id),
        .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
        .w_last_o(w_last),
        .b_valid_i(b_valid), .b_ready_o(b_ready), .b_id_i(b_id),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .ar_len_o(ar_len), .ar_id_o(ar_id),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_id_i(r_id),
        .r_last_i(r_last),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 72'(cmd_ready), 72'd1);
        check({tag, "_busy"}, 72'(busy), 72'd0);
        check({tag, "_done"}, 72'(done), 72'd0);
        check({tag, "_valids"}, 72'({ar_valid, aw_valid, w_valid, rdata_valid}), 72'd0);
        check({tag, "_readys"}, 72'({b_ready, r_ready, wdata_ready}), 72'd0);
    endtask

    // Issue one command; returns the ID the bench expects the DUT to assign.
    task automatic issue_cmd(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                             output logic [7:0] id);
        for (int t = 0; t < 20 && !cmd_ready; t++) @(negedge clk);
        check("cmd_ready", 72'(cmd_ready), 72'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        id        = exp_id;
        exp_id    = exp_id + 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        check("busy_after_cmd", 72'(busy), 72'd1);
    endtask

    task automatic req_phase(input bit wr, input logic [31:0] addr, input logic [3:0] len,
                             input logic [7:0] id, input bit bp);
        bit hs = 1'b0;
        for (int t = 0; t < 100 && !hs; t++) begin
            if (wr) aw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            else    ar_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (wr) check("aw_req", {1'b0, aw_valid, aw_addr, aw_len, aw_id, 26'd0},
                          {1'b0, 1'b1, addr, len, id, 26'd0});
            else    check("ar_req", {1'b0, ar_valid, ar_addr, ar_len, ar_id, 26'd0},
                          {1'b0, 1'b1, addr, len, id, 26'd0});
            hs = wr ? aw_ready : ar_ready;
            @(negedge clk);
        end
        if (!hs) check("req_timeout", 72'd0, 72'd1);
        aw_ready = 1'b0;
        ar_ready = 1'b0;
    endtask

    // Read burst; bad_beat flips r_last on that beat, id_xor corrupts r_id.
    task automatic read_burst(input logic [31:0] addr, input logic [3:0] len, input bit bp,
                              input int bad_beat, input logic [7:0] id_xor);
        logic [7:0]  id;
        logic [71:0] exp;
        issue_cmd(1'b0, addr, len, id);
        req_phase(1'b0, addr, len, id, bp);
        for (int b = 0; b <= int'(len); b++) begin
            bit hs = 1'b0;
            r_valid = 1'b1;
            r_data  = {addr, 32'(b)} ^ 64'hA5A5_0000_0000_5A5A;
            r_id    = id ^ id_xor;
            r_last  = (b == int'(len)) ^ (b == bad_beat);
            sb.push_back({8'hFF, r_data});
            for (int t = 0; t < 100 && !hs; t++) begin
                rdata_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                check("rdata_valid", 72'(rdata_valid), 72'd1);
                check("r_ready", 72'(r_ready), 72'(rdata_ready));
                if (rdata_ready) begin
                    exp = sb.pop_front();
                    check("rdata_beat", {rdata_strb, rdata_data}, exp);
                    check("r_done", 72'(done), 72'(b == int'(len)));
                    hs = 1'b1;
                end else begin
                    check("r_done_stall", 72'(done), 72'd0);
                end
                @(negedge clk);
            end
            if (!hs) check("r_timeout", 72'd0, 72'd1);
        end
        r_valid     = 1'b0;
        r_last      = 1'b0;
        rdata_ready = 1'b0;
        #1;
        check_idle_outputs("after_read");
    endtask

    // Write burst; stop_after < len+1 abandons the burst after that many beats.
    task automatic write_burst(input logic [31:0] addr, input logic [3:0] len, input bit bp,
                               input logic [63:0] base, input int stop_after,
                               input logic [7:0] id_xor);
        logic [7:0]  id;
        logic [71:0] exp;
        issue_cmd(1'b1, addr, len, id);
        req_phase(1'b1, addr, len, id, bp);
        for (int b = 0; b <= int'(len) && b < stop_after; b++) begin
            bit hs = 1'b0;
            wdata_valid = 1'b1;
            wdata_data  = base + 64'(b);
            wdata_strb  = 8'hFF >> (b % 4);
            sb.push_back({wdata_strb, wdata_data});
            for (int t = 0; t < 100 && !hs; t++) begin
                w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                #1;
                check("w_valid", 72'(w_valid), 72'd1);
                check("wdata_ready", 72'(wdata_ready), 72'(w_ready));
                if (w_ready) begin
                    exp = sb.pop_front();
                    check("w_beat", {w_strb, w_data}, exp);
                    check("w_last", 72'(w_last), 72'(b == int'(len)));
                    hs = 1'b1;
                end
                @(negedge clk);
            end
            if (!hs) check("w_timeout", 72'd0, 72'd1);
        end
        w_ready = 1'b0;
        if (stop_after <= int'(len)) return;
        wdata_valid = 1'b0;
        #1;
        check("b_ready", 72'(b_ready), 72'd1);
        check("b_done_early", 72'(done), 72'd0);
        b_valid = 1'b1;
        b_id    = id ^ id_xor;
        #1;
        check("b_done", 72'(done), 72'd1);
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        check_idle_outputs("after_write");
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        exp_id = 8'd0;
        #1;
        check("clear_err", 72'(err), 72'd0);
        check_idle_outputs("after_clear");
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata_data = '0; wdata_strb = '0; rdata_ready = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = '0; ar_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; r_id = '0; r_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_err", 72'(err), 72'd0);
        check("reset_fields", {8'd0, aw_addr, aw_len, aw_id, ar_len, ar_id, 4'd0}, 72'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic read then basic write (IDs 0, 1), then the next command must get ID 2.
        read_burst(32'h1000, 4'd3, 1'b0, -1, 8'h00);
        check("read_err", 72'(err), 72'd0);
        write_burst(32'h2000, 4'd0, 1'b0, 64'hDEAD_BEEF, 99, 8'h00);
        check("write_err", 72'(err), 72'd0);

        // Backpressure on every handshake.
        read_burst(32'h3000, 4'd7, 1'b1, -1, 8'h00);
        write_burst(32'h4000, 4'd5, 1'b1, 64'h1111_2222_3333_0000, 99, 8'h00);
        read_burst(32'h5000, 4'd15, 1'b1, -1, 8'h00);
        check("bp_err", 72'(err), 72'd0);

        // Early r_last: error sticks, burst still runs to beat 3.
        read_burst(32'h6000, 4'd3, 1'b0, 1, 8'h00);
        check("rlast_err", 72'(err), 72'd1);
        write_burst(32'h6100, 4'd1, 1'b0, 64'h77, 99, 8'h00);
        check("err_held", 72'(err), 72'd1);
        pulse_clear();

        // Wrong b_id on a response.
        write_burst(32'h7000, 4'd2, 1'b0, 64'h99, 99, 8'h5A);
        check("bid_err", 72'(err), 72'd1);
        pulse_clear();
        // Wrong r_id on a read.
        read_burst(32'h7100, 4'd1, 1'b0, -1, 8'h01);
        check("rid_err", 72'(err), 72'd1);
        pulse_clear();

        // Reset mid-write after 2 of 4 beats, stream source still asserting valid.
        write_burst(32'h8000, 4'd3, 1'b0, 64'hC0DE, 2, 8'h00);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        check("mid_reset_err", 72'(err), 72'd0);
        check("mid_reset_fields", {8'd0, aw_addr, aw_len, aw_id, ar_len, ar_id, 4'd0}, 72'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        wdata_valid = 1'b0;
        exp_id      = 8'd0;
        sb.delete();
        @(negedge clk);
        read_burst(32'h9000, 4'd2, 1'b0, -1, 8'h00);

        // ID wrap: 257 single-beat reads from a cleared counter end on ID 0.
        pulse_clear();
        for (int i = 0; i < 257; i++) read_burst(32'hA000 + 32'(i * 8), 4'd0, 1'b0, -1, 8'h00);
        check("wrap_err", 72'(err), 72'd0);
        check("wrap_next_id", 72'(exp_id), 72'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
